// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// word geometry and the access-legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    // An access is illegal when it is not word aligned or its word index lies past the array.
    function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[ADDR_LSB-1:0] != '0) ||
               ({{ADDR_LSB{1'b0}}, addr[31:ADDR_LSB]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    // Handshake: master raises req with we/addr/wdata/wstrb stable and holds them until
    // ready; ready is a one-cycle strobe from the slave, and rdata/err are valid only with it.
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, wstrb, input ready, rdata, err);
    modport slave  (input req, we, addr, wdata, wstrb, output ready, rdata, err);
endinterface

// File: rtl/dmem_array.sv
// Single-port byte-enable RAM with a registered read port that clears on reset
// and returns zero for any commit that is not a legal load.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          commit,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (commit && wr_en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit) rdata_d = rd_en ? mem[idx] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request, waits WAIT_STATES cycles, commits
// to the array on RESP entry and pulses ready for one cycle with rdata/err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_responder_if.slave        bus,
    output logic [COUNT_WIDTH-1:0] store_count,
    output dmem_state_e            dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    dmem_state_e            state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   commit;

    // With no wait states the capture edge is also the commit edge, so commit uses the live bus.
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_err;

    assign c_we    = (WAIT_STATES == 0) ? bus.we    : we_q;
    assign c_addr  = (WAIT_STATES == 0) ? bus.addr  : addr_q;
    assign c_wdata = (WAIT_STATES == 0) ? bus.wdata : wdata_q;
    assign c_wstrb = (WAIT_STATES == 0) ? bus.wstrb : wstrb_q;
    assign c_err   = addr_error(c_addr, DEPTH_WORDS);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        count_d    = count_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = commit;
        err_d   = commit && c_err;
        if (commit && c_we && !c_err && (c_wstrb != 4'd0) && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk    (clk),
        .rst_n  (reset),
        .commit (commit),
        .wr_en  (c_we && !c_err),
        .rd_en  (!c_we && !c_err),
        .idx    (c_addr[AW+ADDR_LSB-1:ADDR_LSB]),
        .wdata  (c_wdata),
        .wstrb  (c_wstrb),
        .rdata  (bus.rdata)
    );

    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
    assign store_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (wait states 2/0/3) share one driver,
// selected by sel, and are checked against vector tables and a word-array model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int          sel;
    logic        req_d, we_d;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  wstrb_d;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.req = req_d && (sel == 0);
    assign bus1.req = req_d && (sel == 1);
    assign bus2.req = req_d && (sel == 2);
    assign bus0.we = we_d;       assign bus1.we = we_d;       assign bus2.we = we_d;
    assign bus0.addr = addr_d;   assign bus1.addr = addr_d;   assign bus2.addr = addr_d;
    assign bus0.wdata = wdata_d; assign bus1.wdata = wdata_d; assign bus2.wdata = wdata_d;
    assign bus0.wstrb = wstrb_d; assign bus1.wstrb = wstrb_d; assign bus2.wstrb = wstrb_d;

    logic [15:0] cnt0;
    logic [3:0]  cnt1, cnt2;
    dmem_state_e st0, st1, st2;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .COUNT_WIDTH(16)) u_w2 (
        .clk(clk), .reset(reset), .bus(bus0), .store_count(cnt0), .dbg_state(st0));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .COUNT_WIDTH(4)) u_w0 (
        .clk(clk), .reset(reset), .bus(bus1), .store_count(cnt1), .dbg_state(st1));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .COUNT_WIDTH(4)) u_w3 (
        .clk(clk), .reset(reset), .bus(bus2), .store_count(cnt2), .dbg_state(st2));

    logic        ready_m, err_m;
    logic [31:0] rdata_m, cnt_m;
    dmem_state_e st_m;

    always_comb begin
        ready_m = bus0.ready; err_m = bus0.err; rdata_m = bus0.rdata;
        cnt_m = {16'd0, cnt0}; st_m = st0;
        case (sel)
            1: begin
                ready_m = bus1.ready; err_m = bus1.err; rdata_m = bus1.rdata;
                cnt_m = {28'd0, cnt1}; st_m = st1;
            end
            2: begin
                ready_m = bus2.ready; err_m = bus2.err; rdata_m = bus2.rdata;
                cnt_m = {28'd0, cnt2}; st_m = st2;
            end
            default: ;
        endcase
    end

    // Reference model: plain word array per instance, counts as integers.
    int          w_tab[3]    = '{2, 0, 3};
    int          cmax_tab[3] = '{65535, 15, 15};
    logic [31:0] mdl_mem[3][DEPTH];
    int          mdl_cnt[3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit mdl_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    task automatic mdl_apply(input int s, input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, output logic e_err, output logic [31:0] e_rd);
        e_err = mdl_bad(a);
        e_rd  = 32'd0;
        if (!e_err) begin
            if (we) begin
                if (ws != 4'd0) begin
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) mdl_mem[s][a / 4][8*b +: 8] = wd[8*b +: 8];
                    if (mdl_cnt[s] < cmax_tab[s]) mdl_cnt[s]++;
                end
            end else begin
                e_rd = mdl_mem[s][a / 4];
            end
        end
    endtask

    // Called at a negedge with the selected instance idle; returns edges from req to ready.
    task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input bit drop, output logic g_err, output logic [31:0] g_rd, output int edges);
        we_d = we; addr_d = a; wdata_d = wd; wstrb_d = ws; req_d = 1'b1;
        for (edges = 1; edges <= 40; edges++) begin
            @(posedge clk);
            @(negedge clk);
            if (drop) begin
                req_d = 1'b0; we_d = 1'($urandom); addr_d = $urandom; wdata_d = $urandom; wstrb_d = 4'($urandom);
            end
            if (ready_m) break;
        end
        g_err = err_m;
        g_rd  = rdata_m;
        req_d = 1'b0;
        @(negedge clk);
        check("ready_width", 32'(ready_m), 32'd0);
    endtask

    task automatic do_checked(input int s, input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input bit drop, input string tag);
        logic        e_err, g_err;
        logic [31:0] e_rd, g_rd;
        int          edges;
        sel = s;
        mdl_apply(s, we, a, wd, ws, e_err, e_rd);
        run_txn(we, a, wd, ws, drop, g_err, g_rd, edges);
        check({tag, "_latency"}, edges, w_tab[s] + 1);
        check({tag, "_err"}, 32'(g_err), 32'(e_err));
        if (!we || e_err) check({tag, "_rdata"}, g_rd, e_rd);
        check({tag, "_count"}, cnt_m, mdl_cnt[s]);
    endtask

    typedef struct {
        string       name;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_err, e_err;
        logic [31:0] g_rd, e_rd, a;
        int          edges;

        reset = 1'b0; req_d = 1'b0; we_d = 1'b0; addr_d = '0; wdata_d = '0; wstrb_d = '0; sel = 0;
        for (int s = 0; s < 3; s++) mdl_cnt[s] = 0;

        // Reset state of every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_ready", 32'(ready_m), 32'd0);
            check("rst_err", 32'(err_m), 32'd0);
            check("rst_rdata", rdata_m, 32'd0);
            check("rst_count", cnt_m, 32'd0);
            check("rst_state", 32'(st_m), 32'(IDLE));
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors on the two-wait-state instance.
        vecs.push_back('{"st_100",      1, 32'd100, 32'd25,        4'hF, 0, 0, 32'd0,          32'd1});
        vecs.push_back('{"ld_100",      0, 32'd100, 32'd0,         4'h0, 0, 1, 32'd25,         32'd1});
        vecs.push_back('{"st_96",       1, 32'd96,  32'h11223344,  4'hF, 0, 0, 32'd0,          32'd2});
        vecs.push_back('{"st_96_strb",  1, 32'd96,  32'hAABBCCDD,  4'h5, 0, 0, 32'd0,          32'd3});
        vecs.push_back('{"ld_96",       0, 32'd96,  32'd0,         4'hF, 0, 1, 32'h11BB33DD,   32'd3});
        vecs.push_back('{"st_102",      1, 32'd102, 32'hFFFFFFFF,  4'hF, 1, 1, 32'd0,          32'd3});
        vecs.push_back('{"ld_100_b",    0, 32'd100, 32'd0,         4'h0, 0, 1, 32'd25,         32'd3});
        vecs.push_back('{"ld_256",      0, 32'd256, 32'd0,         4'h0, 1, 1, 32'd0,          32'd3});
        vecs.push_back('{"st_256",      1, 32'd256, 32'h12345678,  4'hF, 1, 1, 32'd0,          32'd3});
        vecs.push_back('{"st_100_zs",   1, 32'd100, 32'd0,         4'h0, 0, 0, 32'd0,          32'd3});
        vecs.push_back('{"ld_100_c",    0, 32'd100, 32'd0,         4'h0, 0, 1, 32'd25,         32'd3});
        vecs.push_back('{"ld_97",       0, 32'd97,  32'd0,         4'h0, 1, 1, 32'd0,          32'd3});
        vecs.push_back('{"st_252",      1, 32'd252, 32'hCAFEF00D,  4'hF, 0, 0, 32'd0,          32'd4});
        vecs.push_back('{"ld_252",      0, 32'd252, 32'd0,         4'h0, 0, 1, 32'hCAFEF00D,   32'd4});
        vecs.push_back('{"ld_hi",       0, 32'h80000064, 32'd0,    4'h0, 1, 1, 32'd0,          32'd4});

        sel = 0;
        foreach (vecs[i]) begin
            mdl_apply(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, e_err, e_rd);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, g_err, g_rd, edges);
            check({vecs[i].name, "_latency"}, edges, 32'd3);
            check({vecs[i].name, "_err"}, 32'(g_err), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rd) check({vecs[i].name, "_rdata"}, g_rd, vecs[i].exp_rd);
            check({vecs[i].name, "_count"}, cnt_m, vecs[i].exp_cnt);
        end

        // Zero wait states, req held high: one response every second cycle.
        sel = 1;
        we_d = 1'b0; addr_d = 32'd256; wstrb_d = 4'h0; req_d = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("w0_hold_ready", 32'(ready_m), 32'((i % 2) == 0));
            if (ready_m) check("w0_hold_err", 32'(err_m), 32'd1);
        end
        req_d = 1'b0;
        @(negedge clk);

        // Saturation of the 4-bit counter, then a zero-strobe store.
        for (int i = 0; i < 20; i++) do_checked(1, 1'b1, 32'(4 * i), $urandom, 4'hF, 1'b0, "sat");
        check("sat_value", cnt_m, 32'hF);
        do_checked(1, 1'b1, 32'd8, $urandom, 4'h0, 1'b0, "sat_zs");
        check("sat_zs_value", cnt_m, 32'hF);

        // Three wait states, req dropped and inputs scrambled right after capture.
        do_checked(2, 1'b1, 32'd0, 32'h5A5A0F0F, 4'hF, 1'b1, "w3_drop_st");
        do_checked(2, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1, "w3_drop_ld");

        // Asynchronous reset during WAIT of a store aborts it.
        do_checked(0, 1'b1, 32'd8, 32'hDEADBEEF, 4'hF, 1'b0, "pre_rst_st");
        do_checked(0, 1'b0, 32'd8, 32'd0, 4'h0, 1'b0, "pre_rst_ld");
        sel = 0;
        we_d = 1'b1; addr_d = 32'd8; wdata_d = 32'h12345678; wstrb_d = 4'hF; req_d = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_d = 1'b0;
        #2 reset = 1'b0;
        for (int s = 0; s < 3; s++) mdl_cnt[s] = 0;
        #1;
        check("midrst_ready", 32'(ready_m), 32'd0);
        check("midrst_rdata", rdata_m, 32'd0);
        check("midrst_err", 32'(err_m), 32'd0);
        check("midrst_count0", 32'(cnt0), 32'd0);
        check("midrst_count1", 32'(cnt1), 32'd0);
        check("midrst_state", 32'(st_m), 32'(IDLE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_hold_ready", 32'(ready_m), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_m), 32'd0);
        do_checked(0, 1'b0, 32'd8, 32'd0, 4'h0, 1'b0, "post_rst_ld");

        // Randomized traffic against the model, after filling every word.
        for (int s = 0; s < 3; s++) begin
            for (int w = 0; w < DEPTH; w++) do_checked(s, 1'b1, 32'(4 * w), $urandom, 4'hF, 1'b0, "fill");
            for (int i = 0; i < 120; i++) begin
                case ($urandom_range(0, 9))
                    7:       a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                    8:       a = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
                    9:       a = ($urandom_range(0, 1) == 1) ? 32'(4 * DEPTH - 4) : 32'(4 * DEPTH);
                    default: a = 32'(4 * $urandom_range(0, DEPTH - 1));
                endcase
                do_checked(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                           $urandom_range(0, 3) == 0, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
